// File: rtl/burst_ram_pkg.sv
// Constants shared between the cache and its backing store: word width,
// line length and the derived line-offset width.
package burst_ram_pkg;

  localparam int DATA_BITWIDTH    = 32;
  localparam int BURST_LENGTH     = 4;
  localparam int LINE_OFFSET_BITS = $clog2(BURST_LENGTH);

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port RAM: one synchronous write port and one registered read port.
// The array is named 'data' so a bench can preload it hierarchically.
module bram_sdp
  import burst_ram_pkg::*;
#(
  parameter int ADDR_BITS = 12,
  parameter int WORD_BITS = DATA_BITWIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WORD_BITS-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WORD_BITS-1:0] rd_data
);

  logic [WORD_BITS-1:0] data [2**ADDR_BITS];

  // NOTE: the array has no reset so it maps onto block RAM; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) data[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= data[rd_addr];
  end

endmodule

// File: rtl/burst_ram.sv
// Line-burst responder below the cache: accepts one read or write command per
// line and streams BURST_LENGTH words, reads after READ_LATENCY_CYCLES wait cycles.
module burst_ram
  import burst_ram_pkg::*;
#(
  parameter int ADDRESS_BITWIDTH    = 12,
  parameter int READ_LATENCY_CYCLES = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [ADDRESS_BITWIDTH-1:0] cmd_addr,
  input  logic [DATA_BITWIDTH-1:0]    wr_data,
  input  logic                        wr_data_valid,
  output logic [DATA_BITWIDTH-1:0]    rd_data,
  output logic                        rd_data_valid,
  output logic                        busy
);

  localparam int WAIT_BITS = (READ_LATENCY_CYCLES > 1) ? $clog2(READ_LATENCY_CYCLES) : 1;
  localparam logic [WAIT_BITS-1:0] WAIT_LAST =
    WAIT_BITS'((READ_LATENCY_CYCLES > 0) ? READ_LATENCY_CYCLES - 1 : 0);
  localparam logic [LINE_OFFSET_BITS-1:0] WORD_LAST = LINE_OFFSET_BITS'(BURST_LENGTH - 1);
  localparam logic [ADDRESS_BITWIDTH-1:0] LINE_MASK = ~ADDRESS_BITWIDTH'(BURST_LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    READ_BURST,
    WRITE_BURST
  } state_t;

  state_t                        state, state_next;
  logic                          ready_en;
  logic [ADDRESS_BITWIDTH-1:0]   line_base;
  logic [LINE_OFFSET_BITS-1:0]   word_idx;
  logic [WAIT_BITS-1:0]          wait_cnt;
  logic                          accept;
  logic                          ram_we;
  logic                          ram_re;
  logic [ADDRESS_BITWIDTH-1:0]   word_addr;

  assign accept    = cmd_valid && cmd_ready;
  // The word index is ORed into a zero-offset base, so a burst never carries out of its line.
  assign word_addr = line_base | ADDRESS_BITWIDTH'(word_idx);

  // ready_en holds cmd_ready low until the first clock edge after reset release.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ready_en <= 1'b0;
    end else begin
      state    <= state_next;
      ready_en <= 1'b1;
    end
  end

  // NOTE: state_next gets a default first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_write)                     state_next = WRITE_BURST;
          else if (READ_LATENCY_CYCLES == 0) state_next = READ_BURST;
          else                               state_next = READ_WAIT;
        end
      end
      READ_WAIT:   if (wait_cnt == WAIT_LAST)                state_next = READ_BURST;
      READ_BURST:  if (word_idx == WORD_LAST)                state_next = IDLE;
      WRITE_BURST: if (wr_data_valid && word_idx == WORD_LAST) state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = ready_en && (state == IDLE);
    busy      = (state != IDLE);
    ram_we    = (state == WRITE_BURST) && wr_data_valid;
    ram_re    = (state == READ_BURST);
  end

  // Read address goes out one cycle ahead of rd_data_valid to cover the registered array read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_base     <= '0;
      word_idx      <= '0;
      wait_cnt      <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= ram_re;
      if (accept) begin
        line_base <= cmd_addr & LINE_MASK;
        word_idx  <= '0;
        wait_cnt  <= '0;
      end else begin
        if (state == READ_WAIT) wait_cnt <= wait_cnt + WAIT_BITS'(1);
        if (ram_re || ram_we)   word_idx <= word_idx + LINE_OFFSET_BITS'(1);
      end
    end
  end

  bram_sdp #(
    .ADDR_BITS (ADDRESS_BITWIDTH),
    .WORD_BITS (DATA_BITWIDTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (ram_we),
    .wr_addr (word_addr),
    .wr_data (wr_data),
    .rd_en   (ram_re),
    .rd_addr (word_addr),
    .rd_data (rd_data)
  );

endmodule
